// File: rtl/vproc_pkg.sv
// Shared vector-processor types: emul encoding, fetch sequencer state and per-operand fetch info.
// Includes the helpers that build a fetch_info and step its register address.
package vproc_pkg;

    localparam int unsigned VREG_W = 5;

    typedef enum logic [1:0] {
        EMUL_1 = 2'd0,
        EMUL_2 = 2'd1,
        EMUL_4 = 2'd2,
        EMUL_8 = 2'd3
    } cfg_emul;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fetch_seq_state;

    typedef struct packed {
        logic              vreg;
        logic              narrow;
        logic              fetch;
        logic              shift;
        logic              clear_hazard;
        logic [VREG_W-1:0] base_addr;
        logic [VREG_W-1:0] vreg_addr;
    } fetch_info;

    function automatic fetch_info fetch_init(
        input logic [VREG_W-1:0] base,
        input logic              vreg,
        input logic              narrow
    );
        fetch_info info;
        info           = '0;
        info.vreg      = vreg;
        info.narrow    = narrow;
        info.base_addr = base;
        info.vreg_addr = base;
        return info;
    endfunction

    // Bases are group-aligned, so OR-ing the offset never carries out of the group.
    function automatic logic [VREG_W-1:0] fetch_update_addr(
        input logic [VREG_W-1:0] base,
        input logic [VREG_W-1:0] k,
        input logic              narrow
    );
        logic [VREG_W-1:0] off;
        if (narrow) begin
            off = k >> 1'b1;
        end else begin
            off = k;
        end
        return base | off;
    endfunction

endpackage

// File: rtl/vproc_fetch_addr_gen.sv
// Per-operand combinational fetch info for step k of a sequence whose final index is last_k.
module vproc_fetch_addr_gen
    import vproc_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic [CNT_W-1:0]  k,
    input  logic [CNT_W-1:0]  last_k,
    input  logic              vreg,
    input  logic              narrow,
    input  logic [VREG_W-1:0] base,
    output fetch_info         info
);

    logic [VREG_W-1:0] k_ext_s;
    logic              final_s;

    assign k_ext_s = VREG_W'(k);

    // Narrow operands fetch on even steps only, so their last fetch is one step early.
    always_comb begin
        final_s = 1'b0;
        if (!narrow) begin
            final_s = (k == last_k);
        end else if (last_k == '0) begin
            final_s = (k == '0);
        end else begin
            final_s = (k == (last_k - CNT_W'(1'b1)));
        end
        info              = fetch_init(base, vreg, narrow);
        info.vreg_addr    = fetch_update_addr(base, k_ext_s, narrow);
        info.fetch        = vreg & (~narrow | ~k[0]);
        info.shift        = info.fetch;
        info.clear_hazard = vreg & final_s;
    end

endmodule

// File: rtl/vproc_fetch_seq.sv
// Operand fetch sequencer: steps a register group of 2^emul registers, one registered step per cycle.
// Outputs are computed from next-cycle state and registered, so a new request appears one cycle later.
module vproc_fetch_seq
    import vproc_pkg::*;
#(
    parameter int unsigned OP_CNT = 2,
    parameter int unsigned ID_W   = 3,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                             clk_i,
    input  logic                             async_rst_ni,
    input  logic                             flush_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [ID_W-1:0]                  req_id_i,
    input  cfg_emul                          req_emul_i,
    input  logic [OP_CNT-1:0]                req_vreg_i,
    input  logic [OP_CNT-1:0]                req_narrow_i,
    input  logic [OP_CNT-1:0][VREG_W-1:0]    req_base_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [ID_W-1:0]                  out_id_o,
    output logic                             first_o,
    output logic                             last_o,
    output fetch_info [OP_CNT-1:0]           out_info_o
);

    fetch_seq_state                  state_r, state_nxt_s;
    logic [CNT_W-1:0]                k_r, k_nxt_s;
    logic [CNT_W-1:0]                last_k_r, last_k_nxt_s, last_k_req_s;
    logic [ID_W-1:0]                 id_r, id_nxt_s;
    logic [OP_CNT-1:0]               vreg_r, vreg_nxt_s;
    logic [OP_CNT-1:0]               narrow_r, narrow_nxt_s;
    logic [OP_CNT-1:0][VREG_W-1:0]   base_r, base_nxt_s;
    logic                            out_valid_r, valid_nxt_s;
    logic                            first_r, last_r;
    fetch_info [OP_CNT-1:0]          info_r, gen_info_s;
    logic                            accept_s, advance_s;

    // A request is taken while idle, or in the cycle the final step is consumed; never during flush.
    assign req_ready_o  = ~flush_i & ((state_r == IDLE) |
                                      ((state_r == BUSY) & last_r & out_ready_i));
    assign accept_s     = req_valid_i & req_ready_o;
    assign advance_s    = out_valid_r & out_ready_i;
    assign last_k_req_s = CNT_W'((32'd1 << req_emul_i) - 32'd1);

    assign out_valid_o = out_valid_r;
    assign out_id_o    = id_r;
    assign first_o     = first_r;
    assign last_o      = last_r;
    assign out_info_o  = info_r;

    // Next-state and next-step selection; flush beats acceptance, which beats stepping.
    always_comb begin
        state_nxt_s  = state_r;
        k_nxt_s      = k_r;
        last_k_nxt_s = last_k_r;
        id_nxt_s     = id_r;
        vreg_nxt_s   = vreg_r;
        narrow_nxt_s = narrow_r;
        base_nxt_s   = base_r;
        valid_nxt_s  = out_valid_r;
        if (flush_i) begin
            state_nxt_s = IDLE;
            k_nxt_s     = '0;
            valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            state_nxt_s  = BUSY;
            k_nxt_s      = '0;
            last_k_nxt_s = last_k_req_s;
            id_nxt_s     = req_id_i;
            vreg_nxt_s   = req_vreg_i;
            narrow_nxt_s = req_narrow_i;
            base_nxt_s   = req_base_i;
            valid_nxt_s  = 1'b1;
        end else if (advance_s) begin
            if (last_r) begin
                state_nxt_s = IDLE;
                k_nxt_s     = '0;
                valid_nxt_s = 1'b0;
            end else begin
                k_nxt_s = k_r + CNT_W'(1'b1);
            end
        end else begin
            valid_nxt_s = out_valid_r;
        end
    end

    for (genvar i = 0; i < OP_CNT; i++) begin : g_op
        vproc_fetch_addr_gen #(
            .CNT_W (CNT_W)
        ) u_addr_gen (
            .k      (k_nxt_s),
            .last_k (last_k_nxt_s),
            .vreg   (vreg_nxt_s[i]),
            .narrow (narrow_nxt_s[i]),
            .base   (base_nxt_s[i]),
            .info   (gen_info_s[i])
        );
    end

    // State, latched request and registered outputs; idle cycles present all-zero step info.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_r     <= IDLE;
            k_r         <= '0;
            last_k_r    <= '0;
            id_r        <= '0;
            vreg_r      <= '0;
            narrow_r    <= '0;
            base_r      <= '0;
            out_valid_r <= 1'b0;
            first_r     <= 1'b0;
            last_r      <= 1'b0;
            info_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            last_k_r    <= last_k_nxt_s;
            id_r        <= id_nxt_s;
            vreg_r      <= vreg_nxt_s;
            narrow_r    <= narrow_nxt_s;
            base_r      <= base_nxt_s;
            out_valid_r <= valid_nxt_s;
            if (valid_nxt_s) begin
                first_r <= (k_nxt_s == '0);
                last_r  <= (k_nxt_s == last_k_nxt_s);
                info_r  <= gen_info_s;
            end else begin
                first_r <= 1'b0;
                last_r  <= 1'b0;
                info_r  <= '0;
            end
        end
    end

endmodule

// File: doc/vproc_fetch_seq.md
VPROC_FETCH_SEQ -- requirements
Module: vproc_fetch_seq

Interface
REQ-001 SHALL have parameter OP_CNT, default 2, meaning number of source operands sequenced in parallel (legal 1..4).
REQ-002 SHALL have parameter ID_W, default 3, meaning width of the instruction ID carried through.
REQ-003 SHALL have parameter CNT_W, default 3, meaning counter width; the maximum group length is 2^CNT_W registers (EMUL_8).
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port async_rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush_i, input, 1, synchronous abort of the current sequence.
REQ-007 SHALL have port req_valid_i / req_ready_o, in/out, 1 each, the request handshake.
REQ-008 SHALL have port req_id_i, input, ID_W, the instruction ID.
REQ-009 SHALL have port req_emul_i, input, cfg_emul, the register-group multiplier of the request.
REQ-010 SHALL have port req_vreg_i / req_narrow_i, input, OP_CNT each, per operand: is a vector register / is a narrow (half-group) operand.
REQ-011 SHALL have port req_base_i, input, OP_CNT x 5, the per-operand base vreg address.
REQ-012 SHALL have port out_valid_o / out_ready_i, out/in, 1 each, the output handshake.
REQ-013 SHALL have port out_id_o, first_o and last_o, outputs, ID_W, 1 and 1, carrying the ID and marking the first and last cycle of the sequence.
REQ-014 SHALL have port out_info_o, output, OP_CNT x fetch_info, the per-operand fetch info for the current cycle.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY.
- IDLE->BUSY on req_valid_i&req_ready_o.
- BUSY->IDLE when the last step is accepted (out_ready_i) and no new request is accepted.
REQ-016 SHALL set the sequence length N=2^req_emul_i (1,2,4,8) and step counter k=0..N-1; k advances only on out_valid_o&out_ready_i.
REQ-017 SHALL register all outputs; the first step SHALL appear at out_valid_o exactly 1 cycle after request acceptance.
REQ-018 SHALL drive req_ready_o = IDLE | (BUSY & last_o & out_ready_i), giving back-to-back sequences with no bubble.
REQ-019 SHALL drive out_info_o[i].vreg_addr per operand: base | k when wide, base | (k>>1) when narrow; formed with fetch_update_addr semantics.
REQ-020 SHALL drive out_info_o[i].fetch = vreg & (~narrow | ~k[0]), and shift = fetch; narrow = req_narrow_i[i]; base_addr and vreg latched from the request.
REQ-021 SHALL assert out_info_o[i].clear_hazard on that operand's final fetch: k==N-1 when wide; k==N-2 when narrow with N>=2; k==0 when narrow with N==1.
REQ-022 SHALL assert first_o at k==0 and last_o at k==N-1; when N==1 both SHALL assert together.
REQ-023 SHALL hold all outputs stable while out_valid_o&~out_ready_i (stall).
REQ-024 SHALL, on flush_i, return the FSM to IDLE, deassert out_valid_o next cycle, and ignore any request presented in the same cycle; flush_i SHALL take priority over all other events.
REQ-025 SHALL give operands with vreg=0 fetch=0 and clear_hazard=0 on all steps.
REQ-026 SHALL treat base addresses as already aligned; OR-ing is used, so no carry or wrap past the group.

Reset
REQ-027 SHALL reset asynchronously on async_rst_ni low to: state IDLE, k=0, out_valid_o=0, first_o=0, last_o=0, out_id_o=0, all out_info_o fields 0; req_ready_o=1 once reset is released.
REQ-028 SHALL, when reset is asserted mid-sequence, discard the sequence with no further output.

Structure
REQ-029 SHALL place in vproc_pkg: the fetch_seq_state enum {IDLE, BUSY}, and reuse of the existing cfg_emul, fetch_info, fetch_init and fetch_update_addr.
REQ-030 SHALL instantiate one sub-module per operand, vproc_fetch_addr_gen (combinational addr/fetch/clear_hazard from k, N, narrow, vreg), via a generate loop over OP_CNT; the FSM and counter stay in the top.

Verification
REQ-031 SHALL cover EMUL_4, op0 wide base 8, op1 narrow base 16, ready tied 1 -> 4 cycles; op0 addr 8,9,10,11; op1 addr 16,16,17,17 with fetch 1,0,1,0; clear_hazard op0 k=3, op1 k=2.
REQ-032 SHALL cover EMUL_1 narrow op -> single cycle with first_o=last_o=1 and clear_hazard=1.
REQ-033 SHALL cover EMUL_2 with out_ready_i low for 3 cycles at k=1 -> outputs frozen, then last_o accepted, and a second pending request starts the next cycle with no bubble.
REQ-034 SHALL cover flush_i at k=2 of an EMUL_8 sequence with req_valid_i high -> out_valid_o=0 next cycle, state IDLE, and that request not accepted.
REQ-035 SHALL cover async_rst_ni pulsed low mid-sequence between clock edges -> outputs zero immediately; after release, a new EMUL_2 request is sequenced from k=0.
REQ-036 SHALL cover OP_CNT=4 with op2 vreg=0 -> op2 fetch and clear_hazard stay 0 for all steps.
